// File: rtl/clock_hhmm_mux_pkg.sv
// Shared types, hour limits and seven-segment lookup for the time-of-day
// counter and its multiplexed display.
package clock_hhmm_mux_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd2_t;

  typedef enum logic [1:0] {
    DIG_MIN_ONES = 2'd0,
    DIG_MIN_TENS = 2'd1,
    DIG_HR_ONES  = 2'd2,
    DIG_HR_TENS  = 2'd3
  } digit_idx_e;

  localparam int unsigned MIN_SEC_HI = 59;
  localparam int unsigned HR_LO      = 0;
  localparam int unsigned HR_HI_24   = 23;
  // 12h hours count 0..11 internally; raw 0 is shown as 12 so the 11->0 wrap toggles pm
  localparam int unsigned HR_HI_12   = 11;
  localparam bcd2_t       HR12_TOP   = 8'h12;

  function automatic bcd2_t to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Active-high segments a..g,dp on bits 7..0
  function automatic logic [7:0] seg_code(input bcd_digit_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE4;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_hhmm_mux_if.sv
// Control inputs and time/display outputs of the clock block.
interface clock_hhmm_mux_if;
  import clock_hhmm_mux_pkg::*;

  logic       run;
  logic       set_min;
  logic       set_hr;
  logic [7:0] Y;
  logic [3:0] K;
  bcd2_t      hh;
  bcd2_t      mm;
  bcd2_t      ss;
  logic       pm;
  logic       sec_tick;

  modport master (
    output run, set_min, set_hr,
    input  Y, K, hh, mm, ss, pm, sec_tick
  );

  modport slave (
    input  run, set_min, set_hr,
    output Y, K, hh, mm, ss, pm, sec_tick
  );
endinterface

// File: rtl/clock_hhmm_mux_bcd_mod_counter.sv
// Two-digit BCD counter LO..HI with wrap flag; clr forces LO and wins over inc.
module bcd_mod_counter
  import clock_hhmm_mux_pkg::*;
#(
  parameter int unsigned LO = 0,
  parameter int unsigned HI = 59
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  inc,
  input  logic  clr,
  output logic  wrap,
  output bcd2_t value
);

  localparam bcd2_t LO_BCD = to_bcd(LO);
  localparam bcd2_t HI_BCD = to_bcd(HI);

  bcd2_t r_value;
  bcd2_t w_next;

  always_comb begin
    w_next = r_value;
    if (r_value == HI_BCD) begin
      w_next = LO_BCD;
    end else if (r_value[3:0] == 4'd9) begin
      w_next = {r_value[7:4] + 4'd1, 4'd0};
    end else begin
      w_next = {r_value[7:4], r_value[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= LO_BCD;
    end else if (clr) begin
      r_value <= LO_BCD;
    end else if (inc) begin
      r_value <= w_next;
    end
  end

  assign wrap  = inc & ~clr & (r_value == HI_BCD);
  assign value = r_value;

endmodule

// File: rtl/clock_hhmm_mux.sv
// HH:MM:SS time-of-day counter with button set and a 4-digit multiplexed
// seven-segment driver; single clock, one-cycle enables.
module clock_hhmm_mux
  import clock_hhmm_mux_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned SCAN_CYCLES = 25_000,
  parameter bit          MODE_12H    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  clock_hhmm_mux_if.slave  bus
);

  localparam int unsigned PRE_W  = $clog2(TICK_CYCLES);
  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned HR_HI  = MODE_12H ? HR_HI_12 : HR_HI_24;

  logic [PRE_W-1:0]  r_pre;
  logic [SCAN_W-1:0] r_scan;
  digit_idx_e        r_dig;
  logic              r_pm;

  logic       w_tick;
  logic       w_ss_wrap;
  logic       w_mm_wrap;
  logic       w_hh_wrap;
  logic       w_hh_inc;
  bcd2_t      w_ss;
  bcd2_t      w_mm;
  bcd2_t      w_hh_raw;
  bcd2_t      w_hh;
  bcd_digit_t w_digit;
  logic       w_dp;
  logic       w_blank;

  // A set_min in the tick cycle swallows the tick entirely
  assign w_tick = bus.run & ~bus.set_min & (r_pre == PRE_W'(TICK_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (bus.set_min) begin
      r_pre <= '0;
    end else if (bus.run) begin
      r_pre <= (r_pre == PRE_W'(TICK_CYCLES - 1)) ? '0 : r_pre + PRE_W'(1);
    end
  end

  bcd_mod_counter #(.LO(0), .HI(MIN_SEC_HI)) u_ss (
    .clock (clock),
    .reset (reset),
    .inc   (w_tick),
    .clr   (bus.set_min),
    .wrap  (w_ss_wrap),
    .value (w_ss)
  );

  bcd_mod_counter #(.LO(0), .HI(MIN_SEC_HI)) u_mm (
    .clock (clock),
    .reset (reset),
    .inc   (bus.set_min | w_ss_wrap),
    .clr   (1'b0),
    .wrap  (w_mm_wrap),
    .value (w_mm)
  );

  // set_hr and a same-cycle carry collapse into a single increment
  assign w_hh_inc = bus.set_hr | (w_mm_wrap & ~bus.set_min);

  bcd_mod_counter #(.LO(HR_LO), .HI(HR_HI)) u_hh (
    .clock (clock),
    .reset (reset),
    .inc   (w_hh_inc),
    .clr   (1'b0),
    .wrap  (w_hh_wrap),
    .value (w_hh_raw)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pm <= 1'b0;
    end else if (MODE_12H && w_hh_wrap) begin
      r_pm <= ~r_pm;
    end
  end

  assign w_hh = (MODE_12H && (w_hh_raw == 8'h00)) ? HR12_TOP : w_hh_raw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scan <= '0;
      r_dig  <= DIG_MIN_ONES;
    end else if (r_scan == SCAN_W'(SCAN_CYCLES - 1)) begin
      r_scan <= '0;
      r_dig  <= digit_idx_e'(r_dig + 2'd1);
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  always_comb begin
    w_digit = '0;
    case (r_dig)
      DIG_MIN_ONES: w_digit = w_mm[3:0];
      DIG_MIN_TENS: w_digit = w_mm[7:4];
      DIG_HR_ONES:  w_digit = w_hh[3:0];
      DIG_HR_TENS:  w_digit = w_hh[7:4];
      default:      w_digit = '0;
    endcase
  end

  // Colon blink: dp on hour-ones during the first half of each second
  assign w_dp    = (r_dig == DIG_HR_ONES) && (r_pre < PRE_W'(TICK_CYCLES / 2));
  assign w_blank = MODE_12H && (r_dig == DIG_HR_TENS) && (w_hh[7:4] == 4'd0);

  assign bus.Y        = w_blank ? 8'hFF : ~(seg_code(w_digit) | {7'd0, w_dp});
  assign bus.K        = ~(4'b0001 << r_dig);
  assign bus.hh       = w_hh;
  assign bus.mm       = w_mm;
  assign bus.ss       = w_ss;
  assign bus.pm       = r_pm;
  assign bus.sec_tick = w_tick;

endmodule

// File: tb/tb_clock_hhmm_mux.sv
// Scoreboard bench: a 24h and a 12h instance receive identical stimulus and are
// compared each cycle against an integer time/prescaler/scan model.
module tb_clock_hhmm_mux;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
  } exp_t;

  localparam logic [7:0] SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                      8'hB6, 8'hBE, 8'hE4, 8'hFE, 8'hF6};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  clock_hhmm_mux_if b24();
  clock_hhmm_mux_if b12();

  clock_hhmm_mux #(.TICK_CYCLES(4), .SCAN_CYCLES(2), .MODE_12H(1'b0)) u24 (
    .clock (clock),
    .reset (reset),
    .bus   (b24)
  );

  clock_hhmm_mux #(.TICK_CYCLES(4), .SCAN_CYCLES(2), .MODE_12H(1'b1)) u12 (
    .clock (clock),
    .reset (reset),
    .bus   (b12)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_pre[2], m_hh[2], m_mm[2], m_ss[2], m_pm[2], m_scan[2], m_dig[2];
  int n_ticks[2];
  exp_t sb[$];

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic exp_t g_time(input int i);
    if (i == 1) return {b12.hh, b12.mm, b12.ss, b12.pm};
    return {b24.hh, b24.mm, b24.ss, b24.pm};
  endfunction

  function automatic logic g_tick(input int i);
    return (i == 1) ? b12.sec_tick : b24.sec_tick;
  endfunction

  function automatic logic [3:0] g_k(input int i);
    return (i == 1) ? b12.K : b24.K;
  endfunction

  function automatic logic [7:0] g_y(input int i);
    return (i == 1) ? b12.Y : b24.Y;
  endfunction

  function automatic logic [3:0] exp_k(input int i);
    logic [3:0] k;
    k = 4'b1111;
    k[m_dig[i]] = 1'b0;
    return k;
  endfunction

  function automatic logic [7:0] exp_y(input int i);
    int d;
    logic [7:0] s;
    case (m_dig[i])
      0:       d = m_mm[i] % 10;
      1:       d = m_mm[i] / 10;
      2:       d = m_hh[i] % 10;
      default: d = m_hh[i] / 10;
    endcase
    if (i == 1 && m_dig[i] == 3 && d == 0) return 8'hFF;
    s = SEG[d];
    if (m_dig[i] == 2 && m_pre[i] < 2) s[0] = 1'b1;
    return ~s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pre[i] = 0; m_mm[i] = 0; m_ss[i] = 0; m_pm[i] = 0;
      m_scan[i] = 0; m_dig[i] = 0; n_ticks[i] = 0;
      m_hh[i] = (i == 1) ? 12 : 0;
    end
  endtask

  task automatic hour_inc(input int i);
    if (i == 0) begin
      m_hh[i] = (m_hh[i] + 1) % 24;
    end else begin
      if (m_hh[i] == 11) m_pm[i] = 1 - m_pm[i];
      m_hh[i] = (m_hh[i] == 12) ? 1 : m_hh[i] + 1;
    end
  endtask

  task automatic model_step(input int i, input logic run, input logic smin, input logic shr);
    logic tick;
    logic carry;
    carry = 1'b0;
    tick = run && (m_pre[i] == 3) && !smin;
    if (smin) m_pre[i] = 0;
    else if (run) m_pre[i] = (m_pre[i] == 3) ? 0 : m_pre[i] + 1;
    if (smin) begin
      m_ss[i] = 0;
      m_mm[i] = (m_mm[i] + 1) % 60;
    end else if (tick) begin
      m_ss[i] = m_ss[i] + 1;
      if (m_ss[i] == 60) begin
        m_ss[i] = 0;
        m_mm[i] = m_mm[i] + 1;
        if (m_mm[i] == 60) begin
          m_mm[i] = 0;
          carry = 1'b1;
        end
      end
    end
    if (shr || carry) hour_inc(i);
    if (m_scan[i] == 1) begin
      m_scan[i] = 0;
      m_dig[i] = (m_dig[i] + 1) % 4;
    end else begin
      m_scan[i] = m_scan[i] + 1;
    end
  endtask

  task automatic drive(input logic run, input logic smin, input logic shr);
    b24.run = run; b24.set_min = smin; b24.set_hr = shr;
    b12.run = run; b12.set_min = smin; b12.set_hr = shr;
  endtask

  // One clock: check combinational outputs, push expected time, pop after the edge
  task automatic cycle(input logic run, input logic smin, input logic shr);
    exp_t e;
    logic t_exp;
    drive(run, smin, shr);
    #1;
    for (int i = 0; i < 2; i++) begin
      t_exp = run && (m_pre[i] == 3) && !smin;
      n_checks++;
      if (g_tick(i) !== t_exp) begin
        n_errors++;
        $display("FAIL sec_tick[%0d]: got %b expected %b at %0t", i, g_tick(i), t_exp, $time);
      end
      if (g_tick(i) === 1'b1) n_ticks[i]++;
      n_checks++;
      if (g_k(i) !== exp_k(i)) begin
        n_errors++;
        $display("FAIL K[%0d]: got %b expected %b at %0t", i, g_k(i), exp_k(i), $time);
      end
      n_checks++;
      if (g_y(i) !== exp_y(i)) begin
        n_errors++;
        $display("FAIL Y[%0d]: got %h expected %h at %0t", i, g_y(i), exp_y(i), $time);
      end
      model_step(i, run, smin, shr);
      e = {bcd(m_hh[i]), bcd(m_mm[i]), bcd(m_ss[i]), 1'(m_pm[i])};
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard[%0d]: got empty queue expected an entry", i);
      end else begin
        e = sb.pop_front();
        if (g_time(i) !== e) begin
          n_errors++;
          $display("FAIL time[%0d]: got %h expected %h at %0t", i, g_time(i), e, $time);
        end
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic preload(input int hrs, input int mins, input int secs);
    do_reset();
    repeat (hrs) cycle(1'b0, 1'b0, 1'b1);
    repeat (mins) cycle(1'b0, 1'b1, 1'b0);
    repeat (secs * 4) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = {(i == 1) ? 8'h12 : 8'h00, 8'h00, 8'h00, 1'b0};
      n_checks++;
      if (g_time(i) !== e) begin
        n_errors++;
        $display("FAIL reset_time[%0d]: got %h expected %h", i, g_time(i), e);
      end
      n_checks++;
      if (g_k(i) !== 4'b1110 || g_y(i) !== 8'h03 || g_tick(i) !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_disp[%0d]: got K=%b Y=%h tick=%b expected K=1110 Y=03 tick=0",
                 i, g_k(i), g_y(i), g_tick(i));
      end
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_minute_rollover();
    do_reset();
    repeat (240) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (n_ticks[i] != 60 || g_time(i).mm !== 8'h01 || g_time(i).ss !== 8'h00) begin
        n_errors++;
        $display("FAIL minute[%0d]: got ticks=%0d mm=%h ss=%h expected ticks=60 mm=01 ss=00",
                 i, n_ticks[i], g_time(i).mm, g_time(i).ss);
      end
    end
  endtask

  task automatic test_day_rollover();
    preload(23, 59, 59);
    n_checks++;
    if (g_time(0) !== {8'h23, 8'h59, 8'h59, 1'b0}) begin
      n_errors++;
      $display("FAIL preload_2359: got %h expected %h", g_time(0), {8'h23, 8'h59, 8'h59, 1'b0});
    end
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (g_time(0) !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL day_wrap_24h: got %h expected %h", g_time(0), {8'h00, 8'h00, 8'h00, 1'b0});
    end
    n_checks++;
    if (g_time(1) !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL midnight_12h: got %h expected %h", g_time(1), {8'h12, 8'h00, 8'h00, 1'b0});
    end
  endtask

  task automatic test_noon_12h();
    preload(11, 59, 59);
    n_checks++;
    if (g_time(1) !== {8'h11, 8'h59, 8'h59, 1'b0}) begin
      n_errors++;
      $display("FAIL preload_1159: got %h expected %h", g_time(1), {8'h11, 8'h59, 8'h59, 1'b0});
    end
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (g_time(1) !== {8'h12, 8'h00, 8'h00, 1'b1}) begin
      n_errors++;
      $display("FAIL noon_12h: got %h expected %h", g_time(1), {8'h12, 8'h00, 8'h00, 1'b1});
    end
  endtask

  task automatic test_setmin_tick();
    int n0;
    preload(0, 59, 0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    n0 = n_ticks[0];
    cycle(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (n_ticks[0] != n0 || g_time(0) !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL setmin_tick: got ticks=%0d time=%h expected ticks=%0d time=%h",
               n_ticks[0], g_time(0), n0, {8'h00, 8'h00, 8'h00, 1'b0});
    end
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (n_ticks[0] != n0 + 1 || g_time(0).ss !== 8'h01) begin
      n_errors++;
      $display("FAIL setmin_pre_clear: got ticks=%0d ss=%h expected ticks=%0d ss=01",
               n_ticks[0], g_time(0).ss, n0 + 1);
    end
  endtask

  task automatic test_sethr_carry();
    preload(23, 59, 59);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (g_time(0) !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL sethr_carry_24h: got %h expected %h", g_time(0), {8'h00, 8'h00, 8'h00, 1'b0});
    end
    n_checks++;
    if (g_time(1) !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL sethr_carry_12h: got %h expected %h", g_time(1), {8'h12, 8'h00, 8'h00, 1'b0});
    end
  endtask

  task automatic test_scan();
    logic [7:0] want;
    logic [3:0] seen;
    preload(12, 34, 0);
    seen = 4'b0000;
    repeat (8) begin
      cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        case (g_k(i))
          4'b1110: begin want = 8'h99; seen[0] = 1'b1; end
          4'b1101: begin want = 8'h0D; seen[1] = 1'b1; end
          4'b1011: begin want = 8'h24; seen[2] = 1'b1; end
          4'b0111: begin want = 8'h9F; seen[3] = 1'b1; end
          default: want = 8'hxx;
        endcase
        n_checks++;
        if (g_y(i) !== want) begin
          n_errors++;
          $display("FAIL scan_1234[%0d]: got K=%b Y=%h expected Y=%h", i, g_k(i), g_y(i), want);
        end
      end
    end
    n_checks++;
    if (seen !== 4'b1111) begin
      n_errors++;
      $display("FAIL scan_digits: got seen=%b expected 1111", seen);
    end
  endtask

  task automatic test_blank_12h();
    preload(1, 0, 0);
    repeat (8) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (b12.K === 4'b0111) begin
        n_checks++;
        if (b12.Y !== 8'hFF || b24.Y !== 8'h03) begin
          n_errors++;
          $display("FAIL hr_tens_blank: got Y12=%h Y24=%h expected Y12=ff Y24=03", b12.Y, b24.Y);
        end
      end
    end
  endtask

  task automatic test_run_hold();
    int n0;
    do_reset();
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    n0 = n_ticks[0];
    repeat (100) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_ticks[0] != n0) begin
      n_errors++;
      $display("FAIL run_hold: got ticks=%0d expected %0d", n_ticks[0], n0);
    end
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (n_ticks[0] != n0 + 1) begin
      n_errors++;
      $display("FAIL run_resume: got ticks=%0d expected %0d", n_ticks[0], n0 + 1);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (g_k(i) !== 4'b1110 || g_y(i) !== 8'h03) begin
        n_errors++;
        $display("FAIL reset_mid_scan[%0d]: got K=%b Y=%h expected K=1110 Y=03", i, g_k(i), g_y(i));
      end
    end
    model_reset();
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    test_reset();
    test_minute_rollover();
    test_day_rollover();
    test_noon_12h();
    test_setmin_tick();
    test_sethr_carry();
    test_scan();
    test_blank_12h();
    test_run_hold();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
